// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue stage: RISC-V M funct3 codes,
// the decoded array-control bundle and its decoder.
package mul_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef struct packed {
        logic is_mul;
        logic is_high;
        logic is_signed;
        logic err;
    } mul_ctrl_t;

    // MULHSU and every undefined funct3 decode to an error op with is_mul cleared.
    function automatic mul_ctrl_t mul_decode(input logic [2:0] funct3);
        mul_ctrl_t ctrl;
        ctrl = '0;
        case (funct3)
            F3_MUL:  begin ctrl.is_mul = 1'b1; ctrl.is_high = 1'b0; ctrl.is_signed = 1'b1; end
            F3_MULH: begin ctrl.is_mul = 1'b1; ctrl.is_high = 1'b1; ctrl.is_signed = 1'b1; end
            F3_MULHU: begin ctrl.is_mul = 1'b1; ctrl.is_high = 1'b1; ctrl.is_signed = 1'b0; end
            default: ctrl.err = 1'b1;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// One valid/ready register slice with synchronous flush; the payload only
// updates on an accepted transfer, so it holds its value while stalled or empty.
module mul_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // NOTE: state registers use non-blocking assignments so every slice samples
    // its neighbour's pre-edge value, giving true pipeline behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
        end
    end

    // NOTE: the payload is reset as well because it drives the array and the
    // result port directly, which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (!flush && adv && in_valid) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/mul_issue_stage.sv
// Issue/capture stage around the external combinational multiplier array:
// S1 holds operands and decoded controls feeding the array, S2 holds the result.
module mul_issue_stage
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_srca,
    input  logic [WIDTH-1:0] in_srcb,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] arr_srca,
    output logic [WIDTH-1:0] arr_srcb,
    output logic             arr_is_mul,
    output logic             arr_is_high,
    output logic             arr_is_signed,
    input  logic [WIDTH-1:0] arr_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int S1_W = 2 * WIDTH + TAG_W + $bits(mul_ctrl_t);
    localparam int S2_W = WIDTH + TAG_W + 1;

    logic             s1_valid;
    logic             s2_ready;
    logic [S1_W-1:0]  s1_in_data;
    logic [S1_W-1:0]  s1_data;
    logic [WIDTH-1:0] s1_srca;
    logic [WIDTH-1:0] s1_srcb;
    logic [TAG_W-1:0] s1_tag;
    mul_ctrl_t        s1_ctrl;
    logic [WIDTH-1:0] s2_in_result;
    logic [S2_W-1:0]  s2_in_data;
    logic [S2_W-1:0]  s2_data;

    assign s1_in_data = {in_srca, in_srcb, in_tag, mul_decode(in_funct3)};

    mul_pipe_reg #(.DATA_W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign {s1_srca, s1_srcb, s1_tag, s1_ctrl} = s1_data;

    // Operands keep their last value when S1 empties; only is_mul is qualified.
    assign arr_srca      = s1_srca;
    assign arr_srcb      = s1_srcb;
    assign arr_is_mul    = s1_valid && s1_ctrl.is_mul;
    assign arr_is_high   = s1_ctrl.is_high;
    assign arr_is_signed = s1_ctrl.is_signed;

    assign s2_in_result = s1_ctrl.err ? '0 : arr_result;
    assign s2_in_data   = {s2_in_result, s1_tag, s1_ctrl.err};

    mul_pipe_reg #(.DATA_W(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {out_result, out_tag, out_err} = s2_data;
    assign busy = s1_valid || out_valid;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Directed bench for mul_issue_stage with a behavioural model of the
// combinational multiplier array hooked to the arr_* ports.
module tb_mul_issue_stage;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_funct3;
    logic [7:0] in_srca;
    logic [7:0] in_srcb;
    logic [3:0] in_tag;
    logic [7:0] arr_srca;
    logic [7:0] arr_srcb;
    logic       arr_is_mul;
    logic       arr_is_high;
    logic       arr_is_signed;
    logic [7:0] arr_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_tag;
    logic       out_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mul_issue_stage #(.WIDTH(8), .TAG_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_funct3     (in_funct3),
        .in_srca       (in_srca),
        .in_srcb       (in_srcb),
        .in_tag        (in_tag),
        .arr_srca      (arr_srca),
        .arr_srcb      (arr_srcb),
        .arr_is_mul    (arr_is_mul),
        .arr_is_high   (arr_is_high),
        .arr_is_signed (arr_is_signed),
        .arr_result    (arr_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .out_err       (out_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: the low byte ignores signedness; the high byte comes from the
    // signed or unsigned 16-bit product. It multiplies even when is_mul=0 so the
    // stage's own zeroing of err results is what gets observed.
    logic [15:0] uprod;
    logic [15:0] sprod;
    always_comb begin
        uprod = {8'h00, arr_srca} * {8'h00, arr_srcb};
        sprod = {{8{arr_srca[7]}}, arr_srca} * {{8{arr_srcb[7]}}, arr_srcb};
        arr_result = arr_is_high ? (arr_is_signed ? sprod[15:8] : uprod[15:8]) : uprod[7:0];
    end

    task automatic drive(input logic v, input logic [2:0] f3, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] tag);
        in_valid  = v;
        in_funct3 = f3;
        in_srca   = a;
        in_srcb   = b;
        in_tag    = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({arr_srca, arr_srcb, arr_is_mul} !== 17'h0) begin errors++; $display("FAIL reset_arr: got %h expected 0", {arr_srca, arr_srcb, arr_is_mul}); end
        checks++; if ({out_result, out_tag, out_err} !== 13'h0) begin errors++; $display("FAIL reset_out_fields: got %h expected 0", {out_result, out_tag, out_err}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accepted at edge N: visible on the array after N, on out_* after N+1,
    // so the consumer takes it at edge N+2.
    task automatic test_single_mul();
        drive(1'b1, F_MUL, 8'h0F, 8'h03, 4'h1);
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid: got %b expected 0", out_valid); end
        checks++; if ({arr_is_mul, arr_is_high, arr_is_signed, arr_srca, arr_srcb} !== {3'b101, 8'h0F, 8'h03}) begin
            errors++; $display("FAIL mul_arr_drive: got %h expected %h", {arr_is_mul, arr_is_high, arr_is_signed, arr_srca, arr_srcb}, {3'b101, 8'h0F, 8'h03}); end
        step();
        checks++; if ({out_valid, out_result, out_tag, out_err} !== {1'b1, 8'h2D, 4'h1, 1'b0}) begin
            errors++; $display("FAIL mul_result: got v=%b r=%h t=%h e=%b expected v=1 r=2d t=1 e=0", out_valid, out_result, out_tag, out_err); end
        step();
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL mul_drain: got valid/busy %b expected 00", {out_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, F_MULHU, 8'hFF, 8'hFF, 4'h2);
        step();
        drive(1'b1, F_MULH, 8'hFF, 8'hFF, 4'h3);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_1: got %b expected 1", in_ready); end
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'hFE, 4'h2}) begin errors++; $display("FAIL b2b_mulhu: got v=%b r=%h t=%h expected v=1 r=fe t=2", out_valid, out_result, out_tag); end
        drive(1'b1, F_MULH, 8'h80, 8'h02, 4'h4);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_2: got %b expected 1", in_ready); end
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h00, 4'h3}) begin errors++; $display("FAIL b2b_mulh_ff: got v=%b r=%h t=%h expected v=1 r=00 t=3", out_valid, out_result, out_tag); end
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'hFF, 4'h4}) begin errors++; $display("FAIL b2b_mulh_80: got v=%b r=%h t=%h expected v=1 r=ff t=4", out_valid, out_result, out_tag); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_unsupported();
        drive(1'b1, F_MULHSU, 8'h12, 8'h34, 4'h7);
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if ({arr_is_mul, busy} !== 2'b01) begin errors++; $display("FAIL err_arr_is_mul: got is_mul/busy %b expected 01", {arr_is_mul, busy}); end
        step();
        checks++; if ({out_valid, out_result, out_tag, out_err} !== {1'b1, 8'h00, 4'h7, 1'b1}) begin
            errors++; $display("FAIL err_result: got v=%b r=%h t=%h e=%b expected v=1 r=00 t=7 e=1", out_valid, out_result, out_tag, out_err); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, F_MUL, 8'h05, 8'h06, 4'h8);
        step();
        drive(1'b1, F_MUL, 8'h07, 8'h07, 4'h9);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_second: got %b expected 1", in_ready); end
        step();
        drive(1'b1, F_MULHU, 8'h10, 8'h20, 4'hA);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_third: got %b expected 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({out_valid, out_result, out_tag, out_err, busy, in_ready, arr_srca} !== {1'b1, 8'h1E, 4'h8, 1'b0, 1'b1, 1'b0, 8'h07}) begin
                errors++; $display("FAIL bp_stall_%0d: got v=%b r=%h t=%h e=%b busy=%b rdy=%b a=%h expected v=1 r=1e t=8 e=0 busy=1 rdy=0 a=07",
                                   i, out_valid, out_result, out_tag, out_err, busy, in_ready, arr_srca); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", in_ready); end
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h31, 4'h9}) begin errors++; $display("FAIL bp_drain_b: got v=%b r=%h t=%h expected v=1 r=31 t=9", out_valid, out_result, out_tag); end
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h02, 4'hA}) begin errors++; $display("FAIL bp_drain_c: got v=%b r=%h t=%h expected v=1 r=02 t=a", out_valid, out_result, out_tag); end
        step();
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_empty: got valid/busy %b expected 00", {out_valid, busy}); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, F_MUL, 8'h01, 8'h01, 4'h1);
        step();
        drive(1'b1, F_MUL, 8'h02, 8'h02, 4'h2);
        step();
        checks++; if ({out_valid, busy, in_ready} !== 3'b110) begin errors++; $display("FAIL flush_full: got valid/busy/rdy %b expected 110", {out_valid, busy, in_ready}); end
        drive(1'b1, F_MUL, 8'h09, 8'h09, 4'h3);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_clear: got valid/busy %b expected 00", {out_valid, busy}); end
        step();
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_discard: got valid/busy %b expected 00", {out_valid, busy}); end
        drive(1'b1, F_MUL, 8'h02, 8'h03, 4'h5);
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h06, 4'h5}) begin errors++; $display("FAIL flush_after: got v=%b r=%h t=%h expected v=1 r=06 t=5", out_valid, out_result, out_tag); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(1'b1, F_MUL, 8'h03, 8'h03, 4'h1);
        step();
        drive(1'b1, F_MUL, 8'h04, 8'h04, 4'h2);
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if ({out_valid, busy} !== 2'b11) begin errors++; $display("FAIL arst_pre: got valid/busy %b expected 11", {out_valid, busy}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, busy, arr_is_mul, out_result} !== {3'b000, 8'h00}) begin
            errors++; $display("FAIL arst_immediate: got v=%b busy=%b is_mul=%b r=%h expected all 0", out_valid, busy, arr_is_mul, out_result); end
        #2;
        rst_n = 1'b1;
        drive(1'b1, F_MUL, 8'h0B, 8'h0B, 4'hC);
        step();
        drive(1'b0, F_MUL, 8'h00, 8'h00, 4'h0);
        checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL arst_no_replay: got valid/busy %b expected 01", {out_valid, busy}); end
        step();
        checks++; if ({out_valid, out_result, out_tag} !== {1'b1, 8'h79, 4'hC}) begin errors++; $display("FAIL arst_after: got v=%b r=%h t=%h expected v=1 r=79 t=c", out_valid, out_result, out_tag); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_unsupported();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_issue_stage.md
Name: mul_issue_stage

Overview:
- Pipelined valid/ready issue and capture stage wrapped around the combinational N-bit multiplier array in the vector execute lane.
- Decodes the RISC-V M funct3 into the array controls (is_mul, is_high, is_signed).
- Registers the operands that drive the array, then registers the array result into an output stage with full backpressure, flush and tag pass-through.
- The array sits between stage S1 and stage S2. It is external to this block and is connected through the arr_* ports.

Parameters:
WIDTH, 8, operand and result width; must match the array's WIDTH.
TAG_W, 4, width of the opaque request tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all in-flight operations.
in_valid  in  1  request valid.
in_ready  out  1  stage can accept a request this cycle.
in_funct3  in  3  M-extension op: 000 MUL, 001 MULH, 011 MULHU, 010 MULHSU.
in_srca  in  WIDTH  operand A.
in_srcb  in  WIDTH  operand B.
in_tag  in  TAG_W  request tag.
arr_srca  out  WIDTH  to array srca.
arr_srcb  out  WIDTH  to array srcb.
arr_is_mul  out  1  to array is_mul.
arr_is_high  out  1  to array is_high.
arr_is_signed  out  1  to array is_signed.
arr_result  in  WIDTH  from array result (combinational).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_result  out  WIDTH  registered result.
out_tag  out  TAG_W  tag of the result.
out_err  out  1  op unsupported (MULHSU or undefined funct3); out_result is 0.
busy  out  1  either stage is occupied.

Behaviour:
- Reset: asynchronous, active-low, rst_n as already decided.
  - Asserting rst_n low clears s1_valid and s2_valid immediately.
  - arr_* outputs are driven to 0. out_valid, out_result, out_tag, out_err and busy reset to 0.
  - Reset mid-operation drops all in-flight work; nothing is replayed.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - out_valid, out_result, out_tag and out_err stay stable while out_valid=1 and out_ready=0.
- Control equations:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = s2_adv
  - in_ready = !s1_valid | s1_adv. in_ready has no dependence on in_valid.
- S1 load on an in transfer:
  - Captures srca, srcb, tag and decoded controls.
  - Decode: MUL → is_mul=1, is_high=0, is_signed=1. MULH → 1,1,1. MULHU → 1,1,0.
  - MULHSU or any other funct3 → is_mul=0 and S1 err flag set. The array output is ignored for an err op.
  - arr_* are driven directly from the S1 registers.
  - If S1 is empty, arr_is_mul=0; arr_srca and arr_srcb hold their last values.
- S2 load when s1_valid & s2_adv:
  - out_result = err ? 0 : arr_result.
  - Tag and err are copied from S1.
  - If s1_valid=0 and s2_adv=1, s2_valid clears.
- Latency and throughput:
  - Accepted at edge N → out_valid at edge N+2.
  - Sustains 1 op/cycle with out_ready held at 1.
  - Order is strictly preserved; no bypass from input to output.
- Backpressure: with out_ready=0 and both stages full, in_ready=0 and nothing advances. When out_ready returns, both stages advance in the same cycle.
- Flush:
  - On an edge with flush=1, s1_valid and s2_valid clear.
  - An in transfer in the same cycle is discarded.
  - Flush has priority over every load.
  - in_ready is still computed normally during flush.
- busy = s1_valid | s2_valid.
- Sign semantics: the array computes MUL low bits as identical for signed and unsigned operands. MULH gives the high half of the signed×signed product; MULHU gives the high half of the unsigned×unsigned product.

Decomposition:
- Package mul_pkg holds:
  - funct3 localparams: F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - mul_ctrl_t struct: is_mul, is_high, is_signed, err.
  - Decode function mul_decode(funct3) returning mul_ctrl_t.
- Natural sub-module: mul_pipe_reg, a parameterised valid/ready register slice with flush.
  - Instantiated twice: S1 carries operands, ctrl and tag; S2 carries result, tag and err.

Test Plan:
1. Reset, then MUL 0x0F×0x03 tag 1, out_ready=1 → at N+2: out_valid=1, out_result=0x2D, out_tag=1, out_err=0.
2. Back-to-back stream: MULHU 0xFF×0xFF, then MULH 0xFF×0xFF, then MULH 0x80×0x02 → results 0xFE, 0x00, 0xFF on consecutive cycles; in_ready stays 1.
3. MULHSU 0x12×0x34 tag 7 → out_err=1, out_result=0x00, out_tag=7; arr_is_mul=0 while the op sits in S1.
4. Hold out_ready=0 and issue 3 ops → the third sees in_ready=0. out_* stay stable and busy=1. Raise out_ready → all three ops drain in order.
5. Flush with both stages full plus an in transfer in the same cycle → next cycle out_valid=0 and busy=0. A later MUL 0x02×0x03 returns 0x06.
6. Deassert rst_n asynchronously between clock edges with ops in flight → out_valid and busy drop immediately without waiting for a clock edge. After release, the next op completes normally.
